// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired CPU control unit: opcodes, ALU codes,
// sequencer states and IR field positions. The datapath ALU uses the same ALU codes.
package cpu_ctrl_pkg;

  localparam int OPC_WIDTH   = 5;
  localparam int ALU_W       = 4;
  localparam int REG_FIELD_W = 4;

  localparam int IR_OPC_MSB = 31;
  localparam int IR_RA_MSB  = 26;
  localparam int IR_RB_MSB  = 22;
  localparam int IR_RC_MSB  = 18;
  localparam int IR_C_MSB   = 18;

  localparam logic [OPC_WIDTH-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_WIDTH-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_WIDTH-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPC_WIDTH-1:0] OP_SHL  = 5'b00110;
  localparam logic [OPC_WIDTH-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPC_WIDTH-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPC_WIDTH-1:0] OP_AND  = 5'b01001;
  localparam logic [OPC_WIDTH-1:0] OP_OR   = 5'b01010;
  localparam logic [OPC_WIDTH-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPC_WIDTH-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPC_WIDTH-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPC_WIDTH-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPC_WIDTH-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPC_WIDTH-1:0] OP_NEG  = 5'b10000;
  localparam logic [OPC_WIDTH-1:0] OP_NOT  = 5'b10001;
  localparam logic [OPC_WIDTH-1:0] OP_MFHI = 5'b10111;
  localparam logic [OPC_WIDTH-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPC_WIDTH-1:0] OP_NOP  = 5'b11001;
  localparam logic [OPC_WIDTH-1:0] OP_HALT = 5'b11010;

  localparam logic [ALU_W-1:0] ALU_NONE = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SHR  = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SHL  = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_ROR  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_ROL  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_MUL  = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_DIV  = 4'b1010;
  localparam logic [ALU_W-1:0] ALU_NEG  = 4'b1011;
  localparam logic [ALU_W-1:0] ALU_NOT  = 4'b1100;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  // Instruction families that share one execute sequence.
  typedef enum logic [2:0] {
    CLS_NONE, CLS_RTYPE, CLS_IMM, CLS_MULDIV, CLS_UNARY, CLS_MFHI, CLS_MFLO, CLS_HALT
  } op_class_t;

  function automatic op_class_t op_class(input logic [OPC_WIDTH-1:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  return CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:       return CLS_IMM;
      OP_MUL, OP_DIV:                 return CLS_MULDIV;
      OP_NEG, OP_NOT:                 return CLS_UNARY;
      OP_MFHI:                        return CLS_MFHI;
      OP_MFLO:                        return CLS_MFLO;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_NONE;
    endcase
  endfunction

  function automatic logic [ALU_W-1:0] alu_code(input logic [OPC_WIDTH-1:0] opc);
    case (opc)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR,  OP_ORI:  return ALU_OR;
      OP_SHR:          return ALU_SHR;
      OP_SHL:          return ALU_SHL;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decode.sv
// Turns the selected IR register field (Ra/Rb/Rc) into one-hot register
// load and bus-drive enables.
module reg_select_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [31:0]         ir,
  input  logic [2:0]          gr_sel,   // one-hot {Gra, Grb, Grc}
  input  logic                rin_en,
  input  logic                rout_en,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out
);

  logic [REG_FIELD_W-1:0] reg_field;
  logic                   field_valid;
  logic                   unused_ir_bits;

  assign unused_ir_bits = ^{ir[IR_OPC_MSB -: OPC_WIDTH], ir[IR_RC_MSB-REG_FIELD_W:0]};

  always_comb begin
    reg_field   = '0;
    field_valid = 1'b1;
    if (gr_sel[2])      reg_field = ir[IR_RA_MSB -: REG_FIELD_W];
    else if (gr_sel[1]) reg_field = ir[IR_RB_MSB -: REG_FIELD_W];
    else if (gr_sel[0]) reg_field = ir[IR_RC_MSB -: REG_FIELD_W];
    else                field_valid = 1'b0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      logic hit;
      assign hit       = field_valid && (int'(reg_field) == gi);
      assign r_in[gi]  = rin_en  & hit;
      assign r_out[gi] = rout_en & hit;
    end
  endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0..T6 control sequencer: fetch with memory stall, then a
// per-opcode execute sequence driving every datapath strobe.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [31:0]         IR,
  input  logic                mem_rdy,
  input  logic                stop,
  output logic                run,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic                PCout,
  output logic                ZLOWout,
  output logic                ZHIout,
  output logic                MDRout,
  output logic                HIout,
  output logic                LOout,
  output logic                Cout,
  output logic                PC_in,
  output logic                IR_in,
  output logic                Y_in,
  output logic                Z_in,
  output logic                MAR_in,
  output logic                MDR_in,
  output logic                HI_in,
  output logic                LO_in,
  output logic                Inc_PC,
  output logic                read,
  output logic [3:0]          ALU_select
);

  state_t           state_reg, state_next;
  logic [OPC_W-1:0] opcode;
  op_class_t        op_cls;
  logic [2:0]       gr_sel;
  logic             rin_en, rout_en;

  assign opcode = IR[IR_OPC_MSB -: OPC_W];
  assign op_cls = op_class(opcode);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_reg <= S_RST;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    run = (state_reg != S_RST) && (state_reg != S_HALT);
    {PCout, ZLOWout, ZHIout, MDRout, HIout, LOout, Cout} = '0;
    {PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, HI_in, LO_in} = '0;
    {Inc_PC, read} = '0;
    ALU_select = ALU_NONE;
    gr_sel     = 3'b000;
    rin_en     = 1'b0;
    rout_en    = 1'b0;

    case (state_reg)
      S_RST: state_next = S_T0;
      S_T0: begin
        if (stop) begin
          state_next = S_HALT;
        end else begin
          {PCout, MAR_in, Inc_PC, Z_in} = 4'b1111;
          state_next = S_T1;
        end
      end
      // Hold in T1 with only read asserted until memory data is valid.
      S_T1: begin
        read = 1'b1;
        if (mem_rdy) begin
          {ZLOWout, PC_in, MDR_in} = 3'b111;
          state_next = S_T2;
        end
      end
      S_T2: begin
        {MDRout, IR_in} = 2'b11;
        state_next = S_T3;
      end
      S_T3: begin
        state_next = S_T0;
        case (op_cls)
          CLS_RTYPE, CLS_IMM: begin
            gr_sel = 3'b010; rout_en = 1'b1; Y_in = 1'b1; state_next = S_T4;
          end
          CLS_MULDIV: begin
            gr_sel = 3'b100; rout_en = 1'b1; Y_in = 1'b1; state_next = S_T4;
          end
          CLS_UNARY: begin
            gr_sel = 3'b010; rout_en = 1'b1; ALU_select = alu_code(opcode);
            Z_in = 1'b1; state_next = S_T4;
          end
          CLS_MFHI: begin HIout = 1'b1; gr_sel = 3'b100; rin_en = 1'b1; end
          CLS_MFLO: begin LOout = 1'b1; gr_sel = 3'b100; rin_en = 1'b1; end
          CLS_HALT: state_next = S_HALT;
          default: ;
        endcase
      end
      S_T4: begin
        state_next = S_T0;
        case (op_cls)
          CLS_RTYPE: begin
            gr_sel = 3'b001; rout_en = 1'b1; ALU_select = alu_code(opcode);
            Z_in = 1'b1; state_next = S_T5;
          end
          CLS_IMM: begin
            Cout = 1'b1; ALU_select = alu_code(opcode); Z_in = 1'b1; state_next = S_T5;
          end
          CLS_MULDIV: begin
            gr_sel = 3'b010; rout_en = 1'b1; ALU_select = alu_code(opcode);
            Z_in = 1'b1; state_next = S_T5;
          end
          CLS_UNARY: begin ZLOWout = 1'b1; gr_sel = 3'b100; rin_en = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        state_next = S_T0;
        case (op_cls)
          CLS_RTYPE, CLS_IMM: begin ZLOWout = 1'b1; gr_sel = 3'b100; rin_en = 1'b1; end
          CLS_MULDIV: begin ZLOWout = 1'b1; LO_in = 1'b1; state_next = S_T6; end
          default: ;
        endcase
      end
      S_T6: begin
        {ZHIout, HI_in} = 2'b11;
        state_next = S_T0;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_RST;
    endcase
  end

  reg_select_decode #(
    .NUM_REGS(NUM_REGS)
  ) u_reg_select_decode (
    .ir      (IR),
    .gr_sel  (gr_sel),
    .rin_en  (rin_en),
    .rout_en (rout_en),
    .r_in    (r_in),
    .r_out   (r_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each scenario queues per-cycle
// stimulus with the expected strobe set, then replays and compares it.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] IR;
  logic        mem_rdy, stop;
  logic        run;
  logic [15:0] r_in, r_out;
  logic        PCout, ZLOWout, ZHIout, MDRout, HIout, LOout, Cout;
  logic        PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, HI_in, LO_in;
  logic        Inc_PC, read;
  logic [3:0]  ALU_select;

  always #5 clk = ~clk;

  control_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut (
    .clk(clk), .clr(clr), .IR(IR), .mem_rdy(mem_rdy), .stop(stop), .run(run),
    .r_in(r_in), .r_out(r_out), .PCout(PCout), .ZLOWout(ZLOWout), .ZHIout(ZHIout),
    .MDRout(MDRout), .HIout(HIout), .LOout(LOout), .Cout(Cout), .PC_in(PC_in),
    .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .MAR_in(MAR_in), .MDR_in(MDR_in),
    .HI_in(HI_in), .LO_in(LO_in), .Inc_PC(Inc_PC), .read(read), .ALU_select(ALU_select)
  );

  typedef struct packed {
    logic run;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic PCout, ZLOWout, ZHIout, MDRout, HIout, LOout, Cout;
    logic PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, HI_in, LO_in;
    logic Inc_PC, read;
    logic [3:0] alu;
  } outs_t;

  typedef struct packed {
    logic [31:0] ir;
    logic        mem_rdy;
    logic        stop;
    outs_t       exp;
    logic [7:0]  step;
  } ent_t;

  ent_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    step_cnt = 0;
  string cur_test;

  localparam logic [31:0] IR_ADD  = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
  localparam logic [31:0] IR_AND  = 32'h4A92_0000;
  localparam logic [31:0] IR_MUL  = 32'h71B0_0000;
  localparam logic [31:0] IR_ADDI = 32'h5897_FFFB;
  localparam logic [31:0] IR_HALT = 32'hD000_0000;
  localparam logic [31:0] IR_NEG  = {5'b10000, 4'd7, 4'd9, 19'd0};
  localparam logic [31:0] IR_MFHI = {5'b10111, 4'd4, 23'd0};
  localparam logic [31:0] IR_MFLO = {5'b11000, 4'd2, 23'd0};
  localparam logic [31:0] IR_UNK  = {5'b00000, 4'd5, 4'd6, 4'd7, 15'd0};
  localparam logic [31:0] IR_NOP  = {5'b11001, 4'd5, 4'd6, 4'd7, 15'd0};
  localparam logic [31:0] IR_NOT  = {5'b10001, 4'd1, 4'd3, 19'd0};

  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.run = 1'b1;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.run = run; o.r_in = r_in; o.r_out = r_out;
    o.PCout = PCout; o.ZLOWout = ZLOWout; o.ZHIout = ZHIout; o.MDRout = MDRout;
    o.HIout = HIout; o.LOout = LOout; o.Cout = Cout; o.PC_in = PC_in; o.IR_in = IR_in;
    o.Y_in = Y_in; o.Z_in = Z_in; o.MAR_in = MAR_in; o.MDR_in = MDR_in;
    o.HI_in = HI_in; o.LO_in = LO_in; o.Inc_PC = Inc_PC; o.read = read; o.alu = ALU_select;
    return o;
  endfunction

  task automatic push(input logic [31:0] ir_v, input logic rdy, input logic stp, input outs_t e);
    ent_t n;
    n.ir = ir_v; n.mem_rdy = rdy; n.stop = stp; n.exp = e; n.step = 8'(step_cnt);
    step_cnt++;
    sb.push_back(n);
  endtask

  task automatic push_t0(input logic [31:0] ir_v);
    outs_t e;
    e = base(); e.PCout = 1'b1; e.MAR_in = 1'b1; e.Inc_PC = 1'b1; e.Z_in = 1'b1;
    push(ir_v, 1'b1, 1'b0, e);
  endtask

  task automatic push_fetch(input logic [31:0] ir_v, input int stalls);
    outs_t e;
    push_t0(ir_v);
    for (int i = 0; i < stalls; i++) begin
      e = base(); e.read = 1'b1;
      push(ir_v, 1'b0, 1'b0, e);
    end
    e = base(); e.read = 1'b1; e.ZLOWout = 1'b1; e.PC_in = 1'b1; e.MDR_in = 1'b1;
    push(ir_v, 1'b1, 1'b0, e);
    e = base(); e.MDRout = 1'b1; e.IR_in = 1'b1;
    push(ir_v, 1'b1, 1'b0, e);
  endtask

  task automatic apply_reset();
    @(negedge clk); clr = 1'b1; mem_rdy = 1'b0; stop = 1'b0;
    @(negedge clk); clr = 1'b0;
    step_cnt = 0;
  endtask

  task automatic test_reset();
    outs_t e, obs;
    ent_t  n;
    cur_test = "test_reset";
    clr = 1'b1; IR = IR_ADD; mem_rdy = 1'b0; stop = 1'b0;
    @(negedge clk); #1;
    obs = sample(); checks++;
    if (obs !== outs_t'(0)) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", obs, outs_t'(0));
    end
    @(negedge clk); clr = 1'b0; #1;
    obs = sample(); checks++;
    if (obs !== outs_t'(0)) begin
      errors++; $display("FAIL reset_rst_state: got %h expected %h", obs, outs_t'(0));
    end
    step_cnt = 0;
    push_fetch(IR_ADD, 0);
    e = base(); e.r_out = 16'h0004; e.Y_in = 1'b1; push(IR_ADD, 1'b1, 1'b0, e);
    while (sb.size() > 0) begin
      n = sb.pop_front();
      @(negedge clk); mem_rdy = n.mem_rdy; stop = n.stop; IR = n.ir; #1;
      obs = sample(); checks++;
      if (obs !== n.exp) begin
        errors++; $display("FAIL %s step %0d: got %h expected %h", cur_test, n.step, obs, n.exp);
      end
    end
    @(negedge clk); #1;
    e = base(); e.r_out = 16'h0008; e.alu = 4'b0001; e.Z_in = 1'b1;
    obs = sample(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL reset_t4_before_abort: got %h expected %h", obs, e);
    end
    #2 clr = 1'b1; #1;
    obs = sample(); checks++;
    if (obs !== outs_t'(0)) begin
      errors++; $display("FAIL reset_async_abort: got %h expected %h", obs, outs_t'(0));
    end
    @(negedge clk); clr = 1'b0; #1;
    obs = sample(); checks++;
    if (obs !== outs_t'(0)) begin
      errors++; $display("FAIL reset_rst_after_abort: got %h expected %h", obs, outs_t'(0));
    end
    push_t0(IR_ADD);
    while (sb.size() > 0) begin
      n = sb.pop_front();
      @(negedge clk); mem_rdy = n.mem_rdy; stop = n.stop; IR = n.ir; #1;
      obs = sample(); checks++;
      if (obs !== n.exp) begin
        errors++; $display("FAIL %s t0_after_release: got %h expected %h", cur_test, obs, n.exp);
      end
    end
    $display("%s: abort and restart sequence done", cur_test);
  endtask

  task automatic test_rtype();
    outs_t e, obs;
    ent_t  n;
    cur_test = "test_rtype";
    apply_reset();
    push_fetch(IR_AND, 0);
    e = base(); e.r_out = 16'h0004; e.Y_in = 1'b1; push(IR_AND, 1'b1, 1'b0, e);
    e = base(); e.r_out = 16'h0010; e.alu = 4'b0011; e.Z_in = 1'b1; push(IR_AND, 1'b1, 1'b0, e);
    e = base(); e.ZLOWout = 1'b1; e.r_in = 16'h0020; push(IR_AND, 1'b1, 1'b0, e);
    push_t0(IR_AND);
    while (sb.size() > 0) begin
      n = sb.pop_front();
      @(negedge clk); mem_rdy = n.mem_rdy; stop = n.stop; IR = n.ir; #1;
      obs = sample(); checks++;
      if (obs !== n.exp) begin
        errors++; $display("FAIL %s step %0d: got %h expected %h", cur_test, n.step, obs, n.exp);
      end
    end
    $display("%s: and R5,R2,R4 done", cur_test);
  endtask

  task automatic test_stall();
    outs_t e, obs;
    ent_t  n;
    int    read_cnt, pcin_cnt, mdrin_cnt, zlow_cnt;
    cur_test = "test_stall";
    apply_reset();
    read_cnt = 0; pcin_cnt = 0; mdrin_cnt = 0; zlow_cnt = 0;
    push_fetch(IR_ADD, 3);
    e = base(); e.r_out = 16'h0004; e.Y_in = 1'b1; push(IR_ADD, 1'b1, 1'b0, e);
    while (sb.size() > 0) begin
      n = sb.pop_front();
      @(negedge clk); mem_rdy = n.mem_rdy; stop = n.stop; IR = n.ir; #1;
      obs = sample(); checks++;
      read_cnt += int'(read); pcin_cnt += int'(PC_in);
      mdrin_cnt += int'(MDR_in); zlow_cnt += int'(ZLOWout);
      if (obs !== n.exp) begin
        errors++; $display("FAIL %s step %0d: got %h expected %h", cur_test, n.step, obs, n.exp);
      end
    end
    checks++;
    if (read_cnt !== 4) begin
      errors++; $display("FAIL stall_read_cycles: got %0d expected 4", read_cnt);
    end
    checks++;
    if (pcin_cnt !== 1 || mdrin_cnt !== 1 || zlow_cnt !== 1) begin
      errors++; $display("FAIL stall_single_fire: got PC_in=%0d MDR_in=%0d ZLOWout=%0d expected 1 each",
                         pcin_cnt, mdrin_cnt, zlow_cnt);
    end
    $display("%s: 3-cycle memory stall done", cur_test);
  endtask

  task automatic test_muldiv();
    outs_t e, obs;
    ent_t  n;
    cur_test = "test_muldiv";
    apply_reset();
    push_fetch(IR_MUL, 0);
    e = base(); e.r_out = 16'h0008; e.Y_in = 1'b1; push(IR_MUL, 1'b1, 1'b0, e);
    e = base(); e.r_out = 16'h0040; e.alu = 4'b1001; e.Z_in = 1'b1; push(IR_MUL, 1'b1, 1'b0, e);
    e = base(); e.ZLOWout = 1'b1; e.LO_in = 1'b1; push(IR_MUL, 1'b1, 1'b0, e);
    e = base(); e.ZHIout = 1'b1; e.HI_in = 1'b1; push(IR_MUL, 1'b1, 1'b0, e);
    push_t0(IR_MUL);
    while (sb.size() > 0) begin
      n = sb.pop_front();
      @(negedge clk); mem_rdy = n.mem_rdy; stop = n.stop; IR = n.ir; #1;
      obs = sample(); checks++;
      if (obs !== n.exp) begin
        errors++; $display("FAIL %s step %0d: got %h expected %h", cur_test, n.step, obs, n.exp);
      end
    end
    $display("%s: mul R3,R6 done", cur_test);
  endtask

  task automatic test_immediate();
    outs_t e, obs;
    ent_t  n;
    cur_test = "test_immediate";
    apply_reset();
    push_fetch(IR_ADDI, 0);
    e = base(); e.r_out = 16'h0004; e.Y_in = 1'b1; push(IR_ADDI, 1'b1, 1'b0, e);
    e = base(); e.Cout = 1'b1; e.alu = 4'b0001; e.Z_in = 1'b1; push(IR_ADDI, 1'b1, 1'b0, e);
    e = base(); e.ZLOWout = 1'b1; e.r_in = 16'h0002; push(IR_ADDI, 1'b1, 1'b0, e);
    push_t0(IR_ADDI);
    while (sb.size() > 0) begin
      n = sb.pop_front();
      @(negedge clk); mem_rdy = n.mem_rdy; stop = n.stop; IR = n.ir; #1;
      obs = sample(); checks++;
      if (obs !== n.exp) begin
        errors++; $display("FAIL %s step %0d: got %h expected %h", cur_test, n.step, obs, n.exp);
      end
    end
    $display("%s: addi R1,R2,-5 done", cur_test);
  endtask

  task automatic test_halt();
    outs_t e, obs;
    ent_t  n;
    cur_test = "test_halt";
    apply_reset();
    push_fetch(IR_HALT, 0);
    e = base(); push(IR_HALT, 1'b1, 1'b0, e);
    for (int i = 0; i < 20; i++)
      push(IR_HALT, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), outs_t'(0));
    while (sb.size() > 0) begin
      n = sb.pop_front();
      @(negedge clk); mem_rdy = n.mem_rdy; stop = n.stop; IR = n.ir; #1;
      obs = sample(); checks++;
      if (obs !== n.exp) begin
        errors++; $display("FAIL %s step %0d: got %h expected %h", cur_test, n.step, obs, n.exp);
      end
    end
    $display("%s: halt instruction done", cur_test);
    cur_test = "test_stop";
    apply_reset();
    e = base(); push(IR_ADD, 1'b1, 1'b1, e);
    for (int i = 0; i < 6; i++) push(IR_ADD, 1'b1, 1'b0, outs_t'(0));
    while (sb.size() > 0) begin
      n = sb.pop_front();
      @(negedge clk); mem_rdy = n.mem_rdy; stop = n.stop; IR = n.ir; #1;
      obs = sample(); checks++;
      if (obs !== n.exp) begin
        errors++; $display("FAIL %s step %0d: got %h expected %h", cur_test, n.step, obs, n.exp);
      end
    end
    $display("%s: stop in T0 done", cur_test);
  endtask

  task automatic test_back_to_back();
    outs_t e, obs;
    ent_t  n;
    cur_test = "test_back_to_back";
    apply_reset();
    push_fetch(IR_NEG, 0);
    e = base(); e.r_out = 16'h0200; e.alu = 4'b1011; e.Z_in = 1'b1; push(IR_NEG, 1'b1, 1'b0, e);
    e = base(); e.ZLOWout = 1'b1; e.r_in = 16'h0080; push(IR_NEG, 1'b1, 1'b0, e);
    push_fetch(IR_MFHI, 0);
    e = base(); e.HIout = 1'b1; e.r_in = 16'h0010; push(IR_MFHI, 1'b1, 1'b0, e);
    push_fetch(IR_MFLO, 0);
    e = base(); e.LOout = 1'b1; e.r_in = 16'h0004; push(IR_MFLO, 1'b1, 1'b0, e);
    push_fetch(IR_UNK, 0);
    push(IR_UNK, 1'b1, 1'b0, base());
    push_fetch(IR_NOP, 0);
    push(IR_NOP, 1'b1, 1'b0, base());
    push_fetch(IR_NOT, 1);
    e = base(); e.r_out = 16'h0008; e.alu = 4'b1100; e.Z_in = 1'b1; push(IR_NOT, 1'b1, 1'b0, e);
    e = base(); e.ZLOWout = 1'b1; e.r_in = 16'h0002; push(IR_NOT, 1'b1, 1'b0, e);
    push_t0(IR_ADD);
    while (sb.size() > 0) begin
      n = sb.pop_front();
      @(negedge clk); mem_rdy = n.mem_rdy; stop = n.stop; IR = n.ir; #1;
      obs = sample(); checks++;
      if (obs !== n.exp) begin
        errors++; $display("FAIL %s step %0d: got %h expected %h", cur_test, n.step, obs, n.exp);
      end
    end
    $display("%s: neg/mfhi/mflo/unlisted/nop/not chain done", cur_test);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_stall();
    test_muldiv();
    test_immediate();
    test_halt();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the 32-bit CPU. It sits directly upstream of `datapath`.
- It decodes the IR word that `datapath` latched and steps through the T0..T6 control sequence. In each step it drives every register/bus strobe and `ALU_select`, replacing hand-driven strobes.
- Each T-step occupies one clk cycle, except T1, which stalls on memory.

Parameters:
- NUM_REGS, 16, general registers. Sets the width of `r_in`/`r_out`.
- OPC_W, 5, opcode width, taken from IR[31:27].

Ports:
- clk  in  1  system clock, rising-edge.
- clr  in  1  asynchronous active-high reset.
- IR  in  32  instruction register contents from `datapath`.
- mem_rdy  in  1  memory data valid on MdataIn during a read.
- stop  in  1  halt request, sampled only in T0.
- run  out  1  high unless in HALT or RST.
- r_in  out  NUM_REGS  one-hot register load enables, bit i = R(i)_in.
- r_out  out  NUM_REGS  one-hot register bus drives, bit i = R(i)out.
- PCout, ZLOWout, ZHIout, MDRout, HIout, LOout, Cout  out  1 each  bus-drive strobes.
- PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, HI_in, LO_in  out  1 each  load strobes.
- Inc_PC, read  out  1 each  PC increment; memory read.
- ALU_select  out  4  ALU operation code.

Behaviour:
- Interface: one clock, `clk`. Reset `clr` is asynchronous and active-high.
- clr=1 forces state RST immediately. While in RST, all outputs are 0, including run.
  - First posedge after clr falls: RST -> T0.
  - clr mid-instruction aborts the instruction with no further strobes.
- Outputs are combinational decodes of the state register and IR. The state register changes only on posedge clk.
- At most one bit of `r_out` is set; it never coincides with another bus driver. ALU_select=0000 whenever Z_in=0.
- IR fields: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C=IR[18:0] (sign extension is done by the datapath on Cout).
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
- T0:
  - stop=1 -> HALT, with no strobes asserted.
  - Otherwise assert PCout, MAR_in, Inc_PC, Z_in -> T1.
- T1: read=1 in every T1 cycle.
  - mem_rdy=0: stay in T1, all other strobes 0.
  - mem_rdy=1: also assert ZLOWout, PC_in, MDR_in -> T2. These fire exactly once per fetch.
- T2: MDRout, IR_in -> T3.
- T3, by opcode:
  - R-type (add, sub, shr, shl, ror, rol, and, or) and immediate (addi, andi, ori): r_out[Rb], Y_in -> T4.
  - mul, div: r_out[Ra], Y_in -> T4.
  - neg, not: r_out[Rb], ALU_select, Z_in -> T4.
  - mfhi: HIout, r_in[Ra] -> T0.
  - mflo: LOout, r_in[Ra] -> T0.
  - nop and any unlisted opcode: no strobes -> T0.
  - halt: -> HALT.
- T4:
  - R-type: r_out[Rc], ALU_select, Z_in -> T5.
  - Immediate: Cout, ALU_select, Z_in -> T5.
  - mul/div: r_out[Rb], ALU_select, Z_in -> T5.
  - neg/not: ZLOWout, r_in[Ra] -> T0.
- T5:
  - R-type/immediate: ZLOWout, r_in[Ra] -> T0.
  - mul/div: ZLOWout, LO_in -> T6.
- T6: ZHIout, HI_in -> T0.
- HALT: run=0, no strobes; exit only via clr.
- Latency with mem_rdy=1:
  - R-type/immediate: 6 cycles.
  - mul/div: 7 cycles.
  - neg/not: 5 cycles.
  - mfhi/mflo/nop: 4 cycles.
- Each mem_rdy=0 cycle in T1 adds one cycle.
- Opcodes: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, mfhi 10111, mflo 11000, nop 11001, halt 11010.
- ALU_select:
  - 0000 none/pass, 0001 add, 0010 sub, 0011 and, 0100 or.
  - 0101 shr, 0110 shl, 0111 ror, 1000 rol.
  - 1001 mul, 1010 div, 1011 neg, 1100 not.
  - addi uses add; andi uses and; ori uses or.

Decomposition:
- Package cpu_ctrl_pkg holds the opcode constants, ALU_select constants, state encoding, and IR field bit positions. `datapath`'s ALU imports the same ALU_select constants.
- Sub-module reg_select_decode takes IR, one-hot {Gra, Grb, Grc}, Rin and Rout. It produces one-hot r_in/r_out via a 4-to-16 decode.
- control_sequencer owns only the FSM and the strobe decode.

Test Plan:
1. Reset abort: clr pulsed during T4 of an add.
   - All outputs go to 0 asynchronously.
   - After release: RST, then T0 next cycle with PCout=MAR_in=Inc_PC=Z_in=1.
2. and R5,R2,R4, IR=0x4A920000, mem_rdy=1.
   - T3: r_out=0x0004, Y_in.
   - T4: r_out=0x0010, ALU_select=0011, Z_in.
   - T5: ZLOWout, r_in=0x0020.
   - Back to T0 six cycles after the first T0.
3. Stall: mem_rdy=0 for 3 cycles in T1.
   - read high for 4 consecutive cycles.
   - PC_in, MDR_in, ZLOWout each high for exactly 1 cycle (the 4th).
4. mul R3,R6, IR=0x71B00000.
   - T3: r_out=0x0008.
   - T4: r_out=0x0040, ALU_select=1001.
   - T5: LO_in.
   - T6: HI_in.
   - 7 cycles total.
5. addi R1,R2,-5, IR=0x5897FFFB.
   - T4: Cout=1, r_out=0, ALU_select=0001.
   - T5: r_in=0x0002.
6. halt, IR=0xD0000000.
   - After T3: run=0, all strobes 0 for 20 cycles.
   - Separately, stop=1 during T0 gives HALT with MAR_in never asserted.
